riscv_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RISC-V pipeline, sitting directly upstream of decode. Owns the PC register, drives the instruction-memory address and captures the returned word into the IF/ID pipeline register. Applies stall, flush and EX-stage redirect. Keeps two free-running performance counters.

---
 rtl/riscv_pkg.sv | 8 +
 rtl/if_id_reg.sv | 36 +++
 rtl/riscv_fetch_stage.sv | 81 ++++++++
 tb/tb_riscv_fetch_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants for fetch, decode and the hazard unit.
// No logic here; latency and backpressure are defined by the stages that use it.
package riscv_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register holding {instr, pc, pc_plus4, valid}; 1-cycle latency.
// en=0 holds the contents (decode stall); clr or rst loads a bubble and wins over en.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int          W_ADDR = XLEN,
    parameter logic [31:0] BUBBLE = NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [31:0]       ld_instr,
    input  logic [W_ADDR-1:0] ld_pc,
    input  logic [W_ADDR-1:0] ld_pc_plus4,
    output logic [31:0]       instr,
    output logic [W_ADDR-1:0] pc,
    output logic [W_ADDR-1:0] pc_plus4,
    output logic              valid
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            instr    <= BUBBLE;
            pc       <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (en) begin
            instr    <= ld_instr;
            pc       <= ld_pc;
            pc_plus4 <= ld_pc_plus4;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/riscv_fetch_stage.sv
// Instruction fetch: PC register, next-PC select, IF/ID register and perf counters.
// Fetch-to-decode latency 1 cycle; stallF holds PC, stallD holds IF/ID, redirect/flush override stalls.
module riscv_fetch_stage
    import riscv_pkg::*;
#(
    parameter int          XLEN      = riscv_pkg::XLEN,
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] pcF,
    input  logic [31:0]     instrF,
    output logic [31:0]     instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pc_plus4D,
    output logic            validD,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     stall_cnt
);

    logic [XLEN-1:0] pc_plus4F;
    logic [XLEN-1:0] pc_next;
    logic            ifid_load;

    // Wraps modulo 2^XLEN by construction.
    assign pc_plus4F = pcF + XLEN'(4);

    // A resolved redirect beats a load-use stall: the stalled instruction is on the wrong path.
    always_comb begin
        pc_next = pc_plus4F;
        if (pc_src_e)
            pc_next = {pc_target_e[XLEN-1:2], 2'b00};
        else if (stallF)
            pc_next = pcF;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pcF <= XLEN'(RESET_PC);
        else
            pcF <= pc_next;
    end

    assign ifid_load = !flushD && !stallD;

    if_id_reg #(
        .W_ADDR (XLEN),
        .BUBBLE (NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .rst         (rst),
        .en          (!stallD),
        .clr         (flushD),
        .ld_instr    (instrF),
        .ld_pc       (pcF),
        .ld_pc_plus4 (pc_plus4F),
        .instr       (instrD),
        .pc          (pcD),
        .pc_plus4    (pc_plus4D),
        .valid       (validD)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (ifid_load)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (stallF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Self-checking bench for riscv_fetch_stage: scoreboard of expected post-edge state plus directed checks.
module tb_riscv_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] pcF;
    logic [31:0] instrF;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pc_plus4D;
    logic        validD;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    typedef struct {
        logic [31:0] pcf;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] p4;
        logic        valid;
        logic [31:0] fc;
        logic [31:0] sc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] m_pc, m_instr, m_pcd, m_p4, m_fc, m_sc;
    logic        m_valid;

    riscv_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stallF      (stallF),
        .stallD      (stallD),
        .flushD      (flushD),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .pcF         (pcF),
        .instrF      (instrF),
        .instrD      (instrD),
        .pcD         (pcD),
        .pc_plus4D   (pc_plus4D),
        .validD      (validD),
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00A0_0113;
            32'h8:   return 32'h0020_81B3;
            32'hC:   return 32'h0031_2223;
            default: return a ^ 32'h1357_0003;
        endcase
    endfunction

    assign instrF = mem_word(pcF);

    // Drive one cycle, record what the outputs must be after the edge, then settle past the monitor.
    task automatic drive(input logic r, input logic sf, input logic sd, input logic fd,
                         input logic src, input logic [31:0] tgt);
        exp_t e;
        rst = r; stallF = sf; stallD = sd; flushD = fd; pc_src_e = src; pc_target_e = tgt;
        if (r) begin
            e.pcf = 32'h0; e.instr = 32'h13; e.pcd = 0; e.p4 = 0; e.valid = 0; e.fc = 0; e.sc = 0;
        end else begin
            e.pcf = src ? {tgt[31:2], 2'b00} : (sf ? m_pc : m_pc + 32'd4);
            e.fc = m_fc; e.sc = sf ? m_sc + 1 : m_sc;
            if (fd) begin
                e.instr = 32'h13; e.pcd = 0; e.p4 = 0; e.valid = 0;
            end else if (sd) begin
                e.instr = m_instr; e.pcd = m_pcd; e.p4 = m_p4; e.valid = m_valid;
            end else begin
                e.instr = mem_word(m_pc); e.pcd = m_pc; e.p4 = m_pc + 32'd4; e.valid = 1;
                e.fc = m_fc + 1;
            end
        end
        sb.push_back(e);
        m_pc = e.pcf; m_instr = e.instr; m_pcd = e.pcd; m_p4 = e.p4; m_valid = e.valid;
        m_fc = e.fc; m_sc = e.sc;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 32'h0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++; if (pcF !== e.pcf) begin n_err++; $display("FAIL sb_pcF got %h want %h", pcF, e.pcf); end
            n_vec++; if (instrD !== e.instr) begin n_err++; $display("FAIL sb_instrD got %h want %h", instrD, e.instr); end
            n_vec++; if (pcD !== e.pcd) begin n_err++; $display("FAIL sb_pcD got %h want %h", pcD, e.pcd); end
            n_vec++; if (pc_plus4D !== e.p4) begin n_err++; $display("FAIL sb_pc_plus4D got %h want %h", pc_plus4D, e.p4); end
            n_vec++; if (validD !== e.valid) begin n_err++; $display("FAIL sb_validD got %b want %b", validD, e.valid); end
            n_vec++; if (fetch_cnt !== e.fc) begin n_err++; $display("FAIL sb_fetch_cnt got %0d want %0d", fetch_cnt, e.fc); end
            n_vec++; if (stall_cnt !== e.sc) begin n_err++; $display("FAIL sb_stall_cnt got %0d want %0d", stall_cnt, e.sc); end
        end
    end

    task automatic test_reset;
        drive(1, 0, 0, 0, 0, 32'h0);
        n_vec++;
        if (pcF !== 32'h0 || instrD !== 32'h13 || validD !== 1'b0 || fetch_cnt !== 0 || stall_cnt !== 0) begin
            n_err++;
            $display("FAIL reset pcF=%h instrD=%h validD=%b fc=%0d sc=%0d want 0/00000013/0/0/0",
                     pcF, instrD, validD, fetch_cnt, stall_cnt);
        end
    endtask

    task automatic test_free_run;
        idle(2);
        n_vec++;
        if (pcF !== 32'h8 || instrD !== 32'h00A0_0113 || pcD !== 32'h4 || validD !== 1'b1 || fetch_cnt !== 32'd2) begin
            n_err++;
            $display("FAIL free_run pcF=%h instrD=%h pcD=%h validD=%b fc=%0d want 8/00a00113/4/1/2",
                     pcF, instrD, pcD, validD, fetch_cnt);
        end
    endtask

    task automatic test_stall;
        drive(0, 1, 1, 0, 0, 32'h0);
        drive(0, 1, 1, 0, 0, 32'h0);
        n_vec++;
        if (pcF !== 32'h8 || instrD !== 32'h00A0_0113 || stall_cnt !== 32'd2 || fetch_cnt !== 32'd2) begin
            n_err++;
            $display("FAIL stall pcF=%h instrD=%h sc=%0d fc=%0d want 8/00a00113/2/2", pcF, instrD, stall_cnt, fetch_cnt);
        end
        idle(1);
        n_vec++;
        if (pcF !== 32'hC || instrD !== 32'h0020_81B3 || fetch_cnt !== 32'd3) begin
            n_err++;
            $display("FAIL stall_resume pcF=%h instrD=%h fc=%0d want c/002081b3/3", pcF, instrD, fetch_cnt);
        end
        // Decode-only stall: PC keeps advancing while IF/ID holds.
        drive(0, 0, 1, 0, 0, 32'h0);
        n_vec++;
        if (pcF !== 32'h10 || instrD !== 32'h0020_81B3 || pcD !== 32'h8) begin
            n_err++;
            $display("FAIL stallD_only pcF=%h instrD=%h pcD=%h want 10/002081b3/8", pcF, instrD, pcD);
        end
    endtask

    task automatic test_redirect;
        drive(0, 0, 0, 1, 1, 32'h40);
        n_vec++;
        if (pcF !== 32'h40 || instrD !== 32'h13 || validD !== 1'b0 || pcD !== 32'h0) begin
            n_err++;
            $display("FAIL redirect pcF=%h instrD=%h validD=%b pcD=%h want 40/00000013/0/0", pcF, instrD, validD, pcD);
        end
        idle(1);
        n_vec++;
        if (instrD !== (32'h40 ^ 32'h1357_0003) || pcD !== 32'h40 || validD !== 1'b1) begin
            n_err++;
            $display("FAIL redirect_follow instrD=%h pcD=%h validD=%b want 13570043/40/1", instrD, pcD, validD);
        end
    endtask

    task automatic test_redirect_over_stall;
        drive(0, 1, 0, 0, 1, 32'h23);
        n_vec++;
        if (pcF !== 32'h20) begin
            n_err++;
            $display("FAIL redirect_vs_stall pcF=%h want 00000020", pcF);
        end
        drive(0, 0, 1, 1, 0, 32'h0);
        n_vec++;
        if (validD !== 1'b0 || instrD !== 32'h13) begin
            n_err++;
            $display("FAIL flush_over_stallD validD=%b instrD=%h want 0/00000013", validD, instrD);
        end
    endtask

    task automatic test_wrap;
        drive(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
        idle(1);
        n_vec++;
        if (pcF !== 32'h0 || pcD !== 32'hFFFF_FFFC || pc_plus4D !== 32'h0 || validD !== 1'b1) begin
            n_err++;
            $display("FAIL pc_wrap pcF=%h pcD=%h pc_plus4D=%h validD=%b want 0/fffffffc/0/1",
                     pcF, pcD, pc_plus4D, validD);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 60; i++) begin
            logic sf, sd, fd, src;
            logic [31:0] tgt;
            sf  = ($urandom_range(0, 3) == 0);
            sd  = ($urandom_range(0, 3) == 0);
            fd  = ($urandom_range(0, 5) == 0);
            src = ($urandom_range(0, 7) == 0);
            tgt = $urandom;
            drive(0, sf, sd, fd | src, src, tgt);
        end
    endtask

    task automatic test_reset_mid;
        drive(1, 0, 0, 0, 0, 32'h0);
        idle(7);
        n_vec++;
        if (fetch_cnt !== 32'd7 || pcF !== 32'h1C) begin
            n_err++;
            $display("FAIL pre_reset fc=%0d pcF=%h want 7/0000001c", fetch_cnt, pcF);
        end
        drive(0, 1, 0, 0, 0, 32'h0);
        drive(1, 1, 1, 1, 1, 32'h80);
        n_vec++;
        if (pcF !== 32'h0 || instrD !== 32'h13 || validD !== 1'b0 || fetch_cnt !== 0 || stall_cnt !== 0) begin
            n_err++;
            $display("FAIL reset_mid pcF=%h instrD=%h validD=%b fc=%0d sc=%0d want 0/00000013/0/0/0",
                     pcF, instrD, validD, fetch_cnt, stall_cnt);
        end
        idle(1);
        n_vec++;
        if (instrD !== 32'h0050_0093 || pcD !== 32'h0 || pc_plus4D !== 32'h4 || validD !== 1'b1 || pcF !== 32'h4) begin
            n_err++;
            $display("FAIL reset_restart instrD=%h pcD=%h p4=%h validD=%b pcF=%h want 00500093/0/4/1/4",
                     instrD, pcD, pc_plus4D, validD, pcF);
        end
    endtask

    initial begin
        rst = 1'b1; stallF = 0; stallD = 0; flushD = 0; pc_src_e = 0; pc_target_e = 0;
        m_pc = 0; m_instr = 0; m_pcd = 0; m_p4 = 0; m_valid = 0; m_fc = 0; m_sc = 0;
        #2;
        test_reset;
        test_free_run;
        test_stall;
        test_redirect;
        test_redirect_over_stall;
        test_wrap;
        test_back_to_back;
        test_reset_mid;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
